// File: rtl/dump_pkg.sv
// Shared definitions for the ROI dump controller.
//   - host command opcodes and fixed reply bytes
//   - top-level sequencer state encoding
//   - byte handshake phase encoding
package dump_pkg;

   localparam logic [7:0] OP_FULL  = 8'h46;  // 'F' full frame
   localparam logic [7:0] OP_ROI   = 8'h44;  // 'D' start/count region
   localparam logic [7:0] OP_ABORT = 8'h41;  // 'A' abort running dump

   localparam logic [7:0] ERR_BYTE = 8'hEE;  // reply to a rejected region
   localparam logic [7:0] HDR_BYTE = 8'hA5;  // line header marker

   typedef enum logic [3:0] {
      IDLE,
      ARGS,
      CHECK,
      ARM,
      WAIT_LINE,
      FETCH,
      SEND,
      GUARD,
      NEXT,
      REARM,
      ERR
   } state_t;

   typedef enum logic [1:0] {
      HS_IDLE,
      HS_SEND,
      HS_GUARD
   } hs_phase_t;

endpackage

// File: rtl/tx_byte_handshake.sv
// One-byte strobe-and-wait towards uart_send.
// A request is accepted only while idle and while the UART reports idle;
// the byte is latched and TX_DATA_READY is high for exactly one cycle
// (HS_SEND). HS_GUARD then waits for the UART to report idle again and
// signals done in that cycle, so two strobes are always separated by an
// observed idle.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   abort_i             drop back to idle (a strobe already out still completes)
//   req_i, byte_i       request to send byte_i
//   tx_idle_i           uart_send idle
//   tx_data_o           latched byte
//   tx_data_ready_o     one-cycle strobe, suppressed while reset is high
//   done_o              byte delivered and UART idle again
//   phase_o             current handshake phase, for observation
module tx_byte_handshake
   import dump_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       abort_i,
   input  logic       req_i,
   input  logic [7:0] byte_i,
   input  logic       tx_idle_i,
   output logic [7:0] tx_data_o,
   output logic       tx_data_ready_o,
   output logic       done_o,
   output hs_phase_t  phase_o
);

   hs_phase_t  phase_q, phase_d;
   logic [7:0] data_q;

   // state register plus byte latch
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         phase_q <= HS_IDLE;
         data_q  <= 8'h00;
      end else begin
         phase_q <= phase_d;
         if (phase_q == HS_IDLE && phase_d == HS_SEND) begin
            data_q <= byte_i;
         end
      end
   end

   // next-state
   always_comb begin
      phase_d = phase_q;
      if (abort_i) begin
         phase_d = HS_IDLE;
      end else begin
         case (phase_q)
            HS_IDLE:  if (req_i && tx_idle_i) phase_d = HS_SEND;
            HS_SEND:  phase_d = HS_GUARD;
            HS_GUARD: if (tx_idle_i) phase_d = HS_IDLE;
            default:  phase_d = HS_IDLE;
         endcase
      end
   end

   // outputs
   always_comb begin
      tx_data_o       = data_q;
      tx_data_ready_o = (phase_q == HS_SEND) && !rst_i;
      done_o          = (phase_q == HS_GUARD) && tx_idle_i && !abort_i;
      phase_o         = phase_q;
   end

endmodule

// File: rtl/roi_dump_controller.sv
// UART-commanded readout sequencer for the camera line buffer.
// Parses 'F' (full frame), 'D' start16,count16 (MSB first) and 'A' (abort),
// then walks lines start..end-1 and columns 0..COLS-1, sending
// PIXEL_DATA[9:2] per pixel through tx_byte_handshake.
// Optional build macro DUMP_LINE_HEADER_EN: each line is preceded by
// 0xA5, line[15:8], line[7:0].
// Handshake semantics: TX_DATA_READY is a single-cycle strobe issued only
// when TX_IDLE=1, and no further strobe follows until TX_IDLE=1 has been
// seen again after it.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   RX_DATA, RX_READY     received byte; RX_READY rising edge marks a byte
//   TX_DATA, TX_DATA_READY, TX_IDLE   byte output to uart_send
//   LINE_READY, RESET_READY_FLAG, INTERESTING_LINE   line capture control
//   READ_ADDRESS, PIXEL_DATA          line buffer read port (1-cycle latency)
//   BUSY                  dump in progress
module roi_dump_controller
   import dump_pkg::*;
#(
   parameter int LINES = 752,
   parameter int COLS  = 480
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [7:0]               RX_DATA,
   input  logic                     RX_READY,
   output logic [7:0]               TX_DATA,
   output logic                     TX_DATA_READY,
   input  logic                     TX_IDLE,
   input  logic                     LINE_READY,
   output logic                     RESET_READY_FLAG,
   output logic [$clog2(LINES)-1:0] INTERESTING_LINE,
   output logic [$clog2(COLS)-1:0]  READ_ADDRESS,
   input  logic [9:0]               PIXEL_DATA,
   output logic                     BUSY
);

   localparam int LW = $clog2(LINES);
   localparam int AW = $clog2(COLS);

   state_t          state_q, state_d;
   logic            rx_q;
   logic [1:0]      argc_q;
   logic [31:0]     args_q;
   logic [LW-1:0]   line_q;
   logic [AW-1:0]   addr_q;
   logic [16:0]     end_q;
   logic            rrf_q, busy_q, settle_q;

   logic            rx_edge, abort, args_bad, last_line, last_col, hdr_pend;
   logic [15:0]     start_w, cnt_w;
   logic [16:0]     sum_w, end_w;
   logic            hs_req, hs_done;
   logic [7:0]      hs_byte;
   hs_phase_t       hs_phase;
   logic            unused_pix;

   assign unused_pix = ^{PIXEL_DATA[1:0], hs_phase};

`ifdef DUMP_LINE_HEADER_EN
   logic [1:0]  hdr_q;      // 0..2 header byte index, 3 = pixels
   logic [15:0] line16;
   assign line16   = 16'(line_q);
   assign hdr_pend = (hdr_q != 2'd3);
`else
   assign hdr_pend = 1'b0;
`endif

   assign rx_edge   = RX_READY && !rx_q;
   assign abort     = rx_edge && (RX_DATA == OP_ABORT) && busy_q;
   assign start_w   = args_q[31:16];
   assign cnt_w     = args_q[15:0];
   assign sum_w     = {1'b0, start_w} + {1'b0, cnt_w};
   assign args_bad  = (start_w >= 16'(LINES)) || (cnt_w == 16'd0);
   assign end_w     = (sum_w > 17'(LINES)) ? 17'(LINES) : sum_w;
   assign last_line = ((17'(line_q) + 17'd1) == end_q);
   assign last_col  = (addr_q == AW'(COLS - 1));

   // state register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next-state
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (rx_edge) begin
               if (RX_DATA == OP_FULL)     state_d = CHECK;
               else if (RX_DATA == OP_ROI) state_d = ARGS;
            end
            ARGS:      if (rx_edge && argc_q == 2'd3) state_d = CHECK;
            CHECK:     state_d = args_bad ? ERR : ARM;
            ARM:       if (LINE_READY) state_d = WAIT_LINE;
            WAIT_LINE: state_d = FETCH;
            // settle_q is low for the first cycle after an address step,
            // while the read data still belongs to the previous column
            FETCH:     if (settle_q && TX_IDLE) state_d = SEND;
            SEND:      state_d = GUARD;
            GUARD:     if (hs_done) state_d = NEXT;
            NEXT:      state_d = (hdr_pend || !last_col) ? FETCH : REARM;
            REARM:     state_d = last_line ? IDLE : ARM;
            ERR:       if (hs_done) state_d = IDLE;
            default:   state_d = IDLE;
         endcase
      end
   end

   // outputs towards the handshake
   always_comb begin
      hs_byte = PIXEL_DATA[9:2];
`ifdef DUMP_LINE_HEADER_EN
      case (hdr_q)
         2'd0:    hs_byte = HDR_BYTE;
         2'd1:    hs_byte = line16[15:8];
         2'd2:    hs_byte = line16[7:0];
         default: hs_byte = PIXEL_DATA[9:2];
      endcase
`endif
      if (state_q == ERR) hs_byte = ERR_BYTE;
      hs_req = !abort && ((state_q == FETCH && settle_q) || state_q == ERR);
   end

   // datapath registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_q     <= 1'b0;
         argc_q   <= 2'd0;
         args_q   <= 32'd0;
         line_q   <= '0;
         addr_q   <= '0;
         end_q    <= 17'd0;
         rrf_q    <= 1'b1;
         busy_q   <= 1'b0;
         settle_q <= 1'b0;
`ifdef DUMP_LINE_HEADER_EN
         hdr_q    <= 2'd0;
`endif
      end else begin
         rx_q     <= RX_READY;
         // the ready flag is released only while a line is being captured or read
         rrf_q    <= !(state_d inside {ARM, WAIT_LINE, FETCH, SEND, GUARD, NEXT});
         busy_q   <= state_d inside {ARM, WAIT_LINE, FETCH, SEND, GUARD, NEXT, REARM};
         settle_q <= (state_q == WAIT_LINE) || (state_q == FETCH);

         if (state_q == IDLE && rx_edge && RX_DATA == OP_FULL)
            args_q <= {16'd0, 16'(LINES)};
         if (state_q == IDLE && rx_edge && RX_DATA == OP_ROI)
            argc_q <= 2'd0;
         if (state_q == ARGS && rx_edge) begin
            args_q <= {args_q[23:0], RX_DATA};
            argc_q <= argc_q + 2'd1;
         end

         if (state_q == CHECK && state_d == ARM) begin
            line_q <= start_w[LW-1:0];
            end_q  <= end_w;
            addr_q <= '0;
         end

         if (state_q == NEXT && state_d != IDLE) begin
`ifdef DUMP_LINE_HEADER_EN
            if (hdr_pend)      hdr_q  <= hdr_q + 2'd1;
            else
`endif
            if (!last_col)     addr_q <= addr_q + AW'(1);
            else               addr_q <= '0;
         end

         if (state_q == REARM && state_d == ARM)
            line_q <= line_q + LW'(1);

`ifdef DUMP_LINE_HEADER_EN
         if (state_d == ARM) hdr_q <= 2'd0;
`endif
      end
   end

   tx_byte_handshake u_tx (
      .clk_i           (CLK),
      .rst_i           (RST),
      .abort_i         (abort),
      .req_i           (hs_req),
      .byte_i          (hs_byte),
      .tx_idle_i       (TX_IDLE),
      .tx_data_o       (TX_DATA),
      .tx_data_ready_o (TX_DATA_READY),
      .done_o          (hs_done),
      .phase_o         (hs_phase)
   );

   assign RESET_READY_FLAG = rrf_q;
   assign INTERESTING_LINE = line_q;
   assign READ_ADDRESS     = addr_q;
   assign BUSY             = busy_q;

endmodule

// File: tb/tb_roi_dump_controller.sv
module tb_roi_dump_controller;
   import dump_pkg::*;

   localparam int LINES = 4;
   localparam int COLS  = 3;
`ifdef DUMP_LINE_HEADER_EN
   localparam int BPL = COLS + 3;
`else
   localparam int BPL = COLS;
`endif

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] RX_DATA;
   logic       RX_READY;
   logic [7:0] TX_DATA;
   logic       TX_DATA_READY;
   logic       TX_IDLE;
   logic       LINE_READY = 1'b0;
   logic       RESET_READY_FLAG;
   logic [1:0] INTERESTING_LINE;
   logic [1:0] READ_ADDRESS;
   logic [9:0] PIXEL_DATA = 10'd0;
   logic       BUSY;

   int total = 0;
   int bad = 0;
   int strobes = 0;
   int rearm_cnt = 0;
   logic busy_seen = 1'b0;
   logic lr_block = 1'b0;
   int tx_cnt = 0;
   logic [15:0] exp_q[$];   // {expected line or 8'hFF, expected byte}

   roi_dump_controller #(.LINES(LINES), .COLS(COLS)) dut (
      .CLK              (CLK),
      .RST              (RST),
      .RX_DATA          (RX_DATA),
      .RX_READY         (RX_READY),
      .TX_DATA          (TX_DATA),
      .TX_DATA_READY    (TX_DATA_READY),
      .TX_IDLE          (TX_IDLE),
      .LINE_READY       (LINE_READY),
      .RESET_READY_FLAG (RESET_READY_FLAG),
      .INTERESTING_LINE (INTERESTING_LINE),
      .READ_ADDRESS     (READ_ADDRESS),
      .PIXEL_DATA       (PIXEL_DATA),
      .BUSY             (BUSY)
   );

   // clock
   always #5 CLK = ~CLK;

   function automatic logic [7:0] pix_byte(input int line, input int addr);
      return 8'(8'h30 + line * 16 + addr * 5);
   endfunction

   // uart_send model: busy for 10 cycles after every strobe
   assign TX_IDLE = (tx_cnt == 0);
   always @(posedge CLK) begin
      if (TX_DATA_READY)   tx_cnt <= 10;
      else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
   end

   // line buffer model: capture completes 5 cycles after the flag is released
   int lr_cnt = 0;
   always @(posedge CLK) begin
      PIXEL_DATA <= {pix_byte(int'(INTERESTING_LINE), int'(READ_ADDRESS)), 2'b01};
      if (RESET_READY_FLAG) begin
         LINE_READY <= 1'b0;
         lr_cnt     <= 0;
      end else if (!lr_block && !LINE_READY) begin
         if (lr_cnt == 4) LINE_READY <= 1'b1;
         else             lr_cnt <= lr_cnt + 1;
      end
   end

   // scoreboard monitor
   always @(negedge CLK) begin
      if (BUSY) busy_seen = 1'b1;
      if (BUSY && RESET_READY_FLAG) rearm_cnt++;
      if (!RST && TX_DATA_READY) begin
         strobes++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_strobe: got byte %h, required no strobe", TX_DATA);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (TX_DATA !== e[7:0]) begin
               bad++;
               $display("FAIL tx_byte: got %h, required %h", TX_DATA, e[7:0]);
            end
            if (e[15:8] != 8'hFF) begin
               total++;
               if (8'(INTERESTING_LINE) !== e[15:8]) begin
                  bad++;
                  $display("FAIL tx_line: got %0d, required %0d", INTERESTING_LINE, e[15:8]);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int got, input int req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   // expected stream for lines [first,last), truncated to max_bytes
   task automatic push_dump(input int first, input int last, input int max_bytes);
      int n = 0;
      for (int l = first; l < last; l++) begin
`ifdef DUMP_LINE_HEADER_EN
         if (n < max_bytes) exp_q.push_back({8'(l), HDR_BYTE});
         n++;
         if (n < max_bytes) exp_q.push_back({8'(l), 8'h00});
         n++;
         if (n < max_bytes) exp_q.push_back({8'(l), 8'(l)});
         n++;
`endif
         for (int a = 0; a < COLS; a++) begin
            if (n < max_bytes) exp_q.push_back({8'(l), pix_byte(l, a)});
            n++;
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold);
      @(negedge CLK);
      RX_DATA  = b;
      RX_READY = 1'b1;
      repeat (hold) @(negedge CLK);
      RX_READY = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   task automatic wait_done(input string name, input int max_cycles);
      int n = 0;
      while ((exp_q.size() != 0 || BUSY || !TX_IDLE) && n < max_cycles) begin
         @(negedge CLK);
         n++;
      end
      total++;
      if (n >= max_cycles) begin
         bad++;
         $display("FAIL %s_timeout: got %0d pending bytes, required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (5) @(negedge CLK);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_tx_data"}, int'(TX_DATA), 0);
      chk({name, "_tx_rdy"},  int'(TX_DATA_READY), 0);
      chk({name, "_rrf"},     int'(RESET_READY_FLAG), 1);
      chk({name, "_line"},    int'(INTERESTING_LINE), 0);
      chk({name, "_addr"},    int'(READ_ADDRESS), 0);
      chk({name, "_busy"},    int'(BUSY), 0);
   endtask

   initial begin
      int s0;
      int n;
      RST = 1'b1;
      RX_DATA = 8'h00;
      RX_READY = 1'b0;
      repeat (3) @(negedge CLK);
      chk_reset_outputs("reset");
      RST = 1'b0;
      repeat (3) @(negedge CLK);

      // full frame
      s0 = strobes; rearm_cnt = 0;
      push_dump(0, LINES, 1000);
      send_byte(OP_FULL, 2);
      wait_done("full", 3000);
      chk("full_strobes", strobes - s0, LINES * BPL);
      chk("full_rearms", rearm_cnt, LINES);
      chk("full_last_line", int'(INTERESTING_LINE), LINES - 1);
      chk("full_rrf_end", int'(RESET_READY_FLAG), 1);
      chk("full_busy_end", int'(BUSY), 0);

      // region clamped to the frame end: lines 2,3
      s0 = strobes; rearm_cnt = 0;
      push_dump(2, LINES, 1000);
      send_byte(OP_ROI, 2); send_byte(8'h00, 2); send_byte(8'h02, 2);
      send_byte(8'h00, 2); send_byte(8'h05, 2);
      wait_done("clamp", 3000);
      chk("clamp_strobes", strobes - s0, 2 * BPL);
      chk("clamp_rearms", rearm_cnt, 2);

      // start out of range, then zero count
      busy_seen = 1'b0;
      exp_q.push_back({8'hFF, ERR_BYTE});
      send_byte(OP_ROI, 2); send_byte(8'h00, 2); send_byte(8'h04, 2);
      send_byte(8'h00, 2); send_byte(8'h01, 2);
      wait_done("err_start", 500);
      exp_q.push_back({8'hFF, ERR_BYTE});
      send_byte(OP_ROI, 2); send_byte(8'h00, 2); send_byte(8'h01, 2);
      send_byte(8'h00, 2); send_byte(8'h00, 2);
      wait_done("err_count", 500);
      chk("err_busy_never", int'(busy_seen), 0);

      // abort after the fourth byte
      s0 = strobes;
      push_dump(0, LINES, 4);
      send_byte(OP_FULL, 2);
      n = 0;
      while (strobes - s0 < 4 && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      chk("abort_reach4", int'(strobes - s0 >= 4), 1);
      send_byte(OP_ABORT, 2);
      repeat (200) @(negedge CLK);
      chk("abort_strobes", strobes - s0, 4);
      chk("abort_busy", int'(BUSY), 0);
      chk("abort_rrf", int'(RESET_READY_FLAG), 1);
      chk("abort_line", int'(INTERESTING_LINE), 3 / BPL);
      s0 = strobes;
      push_dump(0, LINES, 1000);
      send_byte(OP_FULL, 2);
      wait_done("restart", 3000);
      chk("restart_strobes", strobes - s0, LINES * BPL);

      // long RX_READY level counts once; capture stalled for 500 cycles
      lr_block = 1'b1;
      s0 = strobes;
      push_dump(2, LINES, 1000);
      send_byte(OP_ROI, 50); send_byte(8'h00, 2); send_byte(8'h02, 2);
      send_byte(8'h00, 2); send_byte(8'h05, 2);
      repeat (500) @(negedge CLK);
      chk("stall_strobes", strobes - s0, 0);
      chk("stall_busy", int'(BUSY), 1);
      lr_block = 1'b0;
      wait_done("stall", 3000);
      chk("stall_total", strobes - s0, 2 * BPL);

      // reset while in GUARD
      s0 = strobes;
      push_dump(0, LINES, 1);
      send_byte(OP_FULL, 2);
      n = 0;
      while (!TX_DATA_READY && n < 500) begin
         @(negedge CLK);
         n++;
      end
      chk("rst_first_strobe", int'(TX_DATA_READY), 1);
      @(posedge CLK);
      #1 RST = 1'b1;
      chk("rst_no_strobe", int'(TX_DATA_READY), 0);
      @(posedge CLK);
      #1;
      chk_reset_outputs("rst_guard");
      @(negedge CLK);
      RST = 1'b0;
      repeat (100) @(negedge CLK);
      chk("rst_strobes", strobes - s0, 1);
      chk("rst_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // watchdog
   initial begin
      #2000000;
      bad++;
      $display("FAIL watchdog: got no completion, required completion within bound");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/roi_dump_controller.md
Name: roi_dump_controller

Overview:
- UART-commanded readout sequencer for the camera line buffer.
- Parses host command bytes from uart_receive and selects a range of lines (region of interest).
- Steps the line buffer's interesting line, ready-flag re-arm and read address, and feeds pixel bytes (PIXEL_DATA[9:2]) to uart_send one at a time.
- Sits between uart_receive, line_buffer and uart_send in the top level; replaces ad-hoc sequencing there.

Parameters:
- LINES, 752: lines per frame iterated by the dump; INTERESTING_LINE width is $clog2(LINES).
- COLS, 480: pixels per line read back; READ_ADDRESS width is $clog2(COLS).

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  reset; synchronous, active-high.
- RX_DATA  in  8  byte from uart_receive.
- RX_READY  in  1  uart_receive ready level; a rising edge, detected internally, marks one new byte.
- TX_DATA  out  8  byte to uart_send.
- TX_DATA_READY  out  1  one-cycle strobe to uart_send.
- TX_IDLE  in  1  uart_send idle.
- LINE_READY  in  1  line buffer: selected line fully captured.
- RESET_READY_FLAG  out  1  high means the line buffer ready flag is held cleared / disarmed.
- INTERESTING_LINE  out  $clog2(LINES)  line to capture.
- READ_ADDRESS  out  $clog2(COLS)  column read address.
- PIXEL_DATA  in  10  line buffer read data; valid 1 cycle after READ_ADDRESS changes.
- BUSY  out  1  dump in progress.

Behaviour:
- Reset values: TX_DATA=0, TX_DATA_READY=0, RESET_READY_FLAG=1, INTERESTING_LINE=0, READ_ADDRESS=0, BUSY=0; state=IDLE; argument counter=0; RX edge register=0.
- Commands; each byte counts once, on an RX_READY rising edge:
  - 'F' (0x46): full frame, start=0, count=LINES.
  - 'D' (0x44): followed by 4 bytes: start[15:0], then count[15:0], MSB first.
  - 'A' (0x41): abort.
  - Any other byte in IDLE is ignored.
  - While BUSY, only 'A' is honoured; all other bytes are dropped.
- Validation (CHECK state, 1 cycle):
  - start>=LINES or count==0: queue error byte 0xEE, then IDLE.
  - Otherwise end=min(start+count, LINES), computed in 17 bits with no wrap.
- States and transitions:
  - IDLE -> ARGS (after 'D') -> CHECK.
  - IDLE -> CHECK (after 'F').
  - CHECK -> ARM: INTERESTING_LINE=line, READ_ADDRESS=0, RESET_READY_FLAG=0, BUSY=1.
  - ARM -> WAIT_LINE: hold until LINE_READY=1.
  - WAIT_LINE -> FETCH: 1 cycle for read latency.
  - FETCH -> SEND: when TX_IDLE=1, TX_DATA=PIXEL_DATA[9:2], TX_DATA_READY=1 for exactly 1 cycle.
  - SEND -> GUARD: 1 cycle, TX_IDLE ignored.
  - GUARD -> NEXT: once TX_IDLE=1.
- NEXT:
  - If READ_ADDRESS != COLS-1: increment it and return to FETCH.
  - Else: READ_ADDRESS=0 and RESET_READY_FLAG=1 for one cycle (REARM).
  - After REARM, if line+1==end: IDLE, BUSY=0, RESET_READY_FLAG stays 1.
  - Otherwise: line+1 and go to ARM.
- Abort while BUSY: any byte already strobed completes. No further strobes are issued. State goes to IDLE, RESET_READY_FLAG=1, BUSY=0, INTERESTING_LINE unchanged.
- Simultaneous abort and last byte of the dump: result is identical to normal completion.
- ARGS timeout: none. A new 'F'/'D' byte received mid-ARGS is taken as data.
- RST mid-operation: immediate return to reset values; no strobe is issued in the cycle RST is high.
- Exactly one TX_DATA_READY pulse per byte; never two strobes without TX_IDLE=1 observed in GUARD between them.

Optional Feature:
- Macro: DUMP_LINE_HEADER_EN.
- Defined: before the first pixel of every line, after LINE_READY, send 3 bytes: 0xA5, line[15:8], line[7:0]. These use the same SEND/GUARD handshake.
- Undefined: raw pixel bytes only; total bytes = (end-start)*COLS.

Decomposition:
- Package dump_pkg holds:
  - opcodes OP_FULL=0x46, OP_ROI=0x44, OP_ABORT=0x41;
  - ERR_BYTE=0xEE and HDR_BYTE=0xA5;
  - the state enum: IDLE, ARGS, CHECK, ARM, WAIT_LINE, FETCH, SEND, GUARD, NEXT, REARM, ERR.
- One sub-module, tx_byte_handshake, owns the SEND/GUARD strobe-and-wait logic. It takes a byte plus a request and returns done.

Test Plan:
- 'F' with LINES=4, COLS=3, uart model idle 10 cycles after each strobe -> exactly 12 strobes, bytes = PIXEL_DATA[9:2], INTERESTING_LINE 0..3, RESET_READY_FLAG pulses between lines, BUSY falls after byte 12.
- 'D',0x00,0x02,0x00,0x05 with LINES=4 -> lines 2,3 only (clamped), 6 bytes.
- 'D',0x00,0x04,0x00,0x01 with LINES=4 -> single 0xEE byte, BUSY stays 0; 'D' with count=0 -> 0xEE.
- 'A' injected after byte 4 of a full dump -> byte 4 completes, no byte 5, RESET_READY_FLAG=1, then a new 'F' restarts at line 0.
- LINE_READY held low 500 cycles -> no strobe; RX_READY held high for 50 cycles -> counted as one byte.
- RST asserted in GUARD -> next cycle all outputs at reset values. With DUMP_LINE_HEADER_EN, 'F' -> 3+COLS bytes per line, header 0xA5,0x00,line.
